// File: rtl/ifetch_unit.sv
// ifetch_unit: IDLE/FETCH/EXEC instruction fetch with next-pc selection and jal link register
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] Instruction,
    output logic        inst_valid,
    output logic [31:0] branch_base_addr,
    output logic [31:0] link_addr,
    input  logic [31:0] AddrResult,
    input  logic        Zero,
    input  logic [31:0] ReadData1,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        stall
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, link_q, link_d, pc_plus4, target;
    logic        valid_q, valid_d, taken;
    assign pc_plus4         = pc_q + 32'd4;
    assign imem_req         = state_q == FETCH;
    assign imem_addr        = pc_q;
    assign Instruction      = instr_q;
    assign inst_valid       = valid_q;
    assign branch_base_addr = pc_plus4;
    assign link_addr        = link_q;
    always_comb begin
        taken   = (Branch && Zero) || (nBranch && !Zero);
        target  = Jr ? ReadData1 : taken ? AddrResult :
                  (Jmp || Jal) ? {pc_plus4[31:28], instr_q[25:0], 2'b00} : pc_plus4;
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        link_d  = link_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: if (imem_ready) begin
                state_d = EXEC;
                instr_d = imem_rdata;
                valid_d = 1'b1;
            end
            EXEC: if (!stall) begin
                state_d = FETCH;
                pc_d    = target & ~32'd3;
                valid_d = 1'b0;
                link_d  = Jal ? pc_plus4 : link_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            link_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            link_q  <= link_d;
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed fetch/exec sequence with an expected-fetch-address scoreboard
module tb_ifetch_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        imem_req, imem_ready = 1'b0, Zero = 1'b0, inst_valid;
    logic        Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0, stall = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0, Instruction, branch_base_addr, link_addr;
    logic [31:0] AddrResult = '0, ReadData1 = '0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_link = '0, cur_pc = '0, cur_instr = '0;
    int          vectors = 0, errors = 0;

    ifetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .Instruction(Instruction),
        .inst_valid(inst_valid), .branch_base_addr(branch_base_addr), .link_addr(link_addr),
        .AddrResult(AddrResult), .Zero(Zero), .ReadData1(ReadData1), .Branch(Branch),
        .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called on a negedge with the DUT in FETCH; stalls the memory for delay cycles
    task automatic fetch(input logic [31:0] instr, input int delay);
        chkb("sb_nonempty", exp_q.size() > 0, 1'b1);
        cur_pc    = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        cur_instr = instr;
        chkb("fetch_req", imem_req, 1'b1);
        chkb("fetch_valid", inst_valid, 1'b0);
        chk("imem_addr", imem_addr, cur_pc);
        chk("branch_base", branch_base_addr, cur_pc + 32'd4);
        chk("link_hold", link_addr, exp_link);
        for (int i = 0; i < delay; i++) begin
            Jal = 1'b1; Jr = 1'b1; ReadData1 = 32'hBAD00000; imem_rdata = 32'hFFFFFFFF;
            @(negedge clk);
            chkb("wait_req", imem_req, 1'b1);
            chk("wait_addr", imem_addr, cur_pc);
            chk("wait_link", link_addr, exp_link);
        end
        Jal = 1'b0; Jr = 1'b0; ReadData1 = '0;
        imem_ready = 1'b1; imem_rdata = instr;
        @(negedge clk);
        imem_ready = 1'b0; imem_rdata = 32'h0BADF00D;
        chkb("exec_valid", inst_valid, 1'b1);
        chk("exec_instr", Instruction, instr);
        chkb("exec_req", imem_req, 1'b0);
    endtask

    task automatic exec(input logic jr, input logic br, input logic nbr, input logic jmp,
                        input logic jal, input logic zero, input logic [31:0] addr_res,
                        input logic [31:0] rd1, input int stalls, input logic [31:0] next_pc);
        Jr = jr; Branch = br; nBranch = nbr; Jmp = jmp; Jal = jal; Zero = zero;
        AddrResult = addr_res; ReadData1 = rd1;
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            @(negedge clk);
            chk("stall_instr", Instruction, cur_instr);
            chkb("stall_valid", inst_valid, 1'b1);
            chk("stall_pc", imem_addr, cur_pc);
            chkb("stall_req", imem_req, 1'b0);
        end
        stall = 1'b0;
        exp_q.push_back(next_pc);
        if (jal) exp_link = cur_pc + 32'd4;
        @(negedge clk);
        Jr = 1'b0; Branch = 1'b0; nBranch = 1'b0; Jmp = 1'b0; Jal = 1'b0; Zero = 1'b0;
        AddrResult = '0; ReadData1 = '0;
        chk("link_addr", link_addr, exp_link);
    endtask

    initial begin
        #3;
        chkb("rst_req", imem_req, 1'b0);
        chkb("rst_valid", inst_valid, 1'b0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_link", link_addr, 32'h0);
        chk("rst_pc", imem_addr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chkb("idle_req", imem_req, 1'b0);
        @(negedge clk);
        exp_q.push_back(32'h0);
        // sequential stream
        fetch(32'h00000001, 0); exec(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4);
        fetch(32'h00000002, 0); exec(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8);
        fetch(32'h00000003, 0); exec(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hC);
        fetch(32'h00000004, 0); exec(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10);
        // beq taken, then jr beats a taken branch, then beq not taken, bne taken with low bits forced
        fetch(32'h10000010, 0); exec(0, 1, 0, 0, 0, 1, 32'h40, 0, 0, 32'h40);
        fetch(32'h03E00008, 0); exec(1, 1, 0, 0, 0, 1, 32'h80, 32'h10, 0, 32'h10);
        fetch(32'h10000010, 0); exec(0, 1, 0, 0, 0, 0, 32'h40, 0, 0, 32'h14);
        fetch(32'h14000002, 0); exec(0, 0, 1, 0, 0, 0, 32'h21, 0, 0, 32'h20);
        fetch(32'h03E00008, 0); exec(1, 0, 0, 0, 0, 0, 0, 32'h00400020, 0, 32'h00400020);
        // jal then jr back to the link address
        fetch(32'h0C100000, 0); exec(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h00400000);
        chk("jal_link", link_addr, 32'h00400024);
        fetch(32'h03E00008, 0); exec(1, 0, 0, 1, 0, 0, 0, 32'h00400024, 0, 32'h00400024);
        // slow memory and stalled retire, then jr to the top word
        fetch(32'hCAFE0001, 5); exec(1, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFE, 3, 32'hFFFFFFFC);
        fetch(32'h00000005, 0); exec(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        fetch(32'hA5A50001, 0); exec(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4);
        // reset mid-fetch with a late ready on release
        chkb("sb_nonempty", exp_q.size() > 0, 1'b1);
        cur_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        chkb("pre_rst_req", imem_req, 1'b1);
        chk("pre_rst_addr", imem_addr, cur_pc);
        #2 rst_n = 1'b0;
        exp_link = '0;
        #1;
        chkb("async_req", imem_req, 1'b0);
        chk("async_pc", imem_addr, 32'h0);
        chkb("async_valid", inst_valid, 1'b0);
        chk("async_instr", Instruction, 32'h0);
        chk("async_link", link_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("late_ready_instr", Instruction, 32'h0);
        chkb("late_ready_valid", inst_valid, 1'b0);
        exp_q.push_back(32'h0);
        fetch(32'h00001234, 0); exec(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4);
        fetch(32'h00005678, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, giving the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32 bits: word address of the instruction being fetched; equals pc.
REQ-006 SHALL have port imem_rdata, input, 32 bits: instruction word; valid when imem_ready=1.
REQ-007 SHALL have port imem_ready, input, 1 bit: memory read complete.
REQ-008 SHALL have port Instruction, output, 32 bits: latched current instruction, fed to decode and execute.
REQ-009 SHALL have port inst_valid, output, 1 bit: Instruction is valid and executing.
REQ-010 SHALL have port branch_base_addr, output, 32 bits: pc+4, fed to the executor pc input.
REQ-011 SHALL have port link_addr, output, 32 bits: registered return address for jal.
REQ-012 SHALL have inputs AddrResult (32 bits) and Zero (1 bit) from the executor.
REQ-013 SHALL have input ReadData1 (32 bits): rs value, the jr target.
REQ-014 SHALL have 1-bit control inputs Branch (beq), nBranch (bne), Jmp, Jal and Jr.
REQ-015 SHALL have input stall, 1 bit: downstream not ready to retire the current instruction.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH and EXEC.
REQ-017 IDLE SHALL last exactly one cycle, then go to FETCH.
REQ-018 In FETCH: imem_req=1 and imem_addr=pc.
REQ-019 When imem_ready=1 in FETCH, the next edge SHALL latch imem_rdata into Instruction, set inst_valid=1 and enter EXEC.
REQ-020 While imem_ready=0 in FETCH, the FSM SHALL hold indefinitely; imem_req and imem_addr stay stable.
REQ-021 In EXEC, imem_req SHALL be 0.
REQ-022 In EXEC with stall=1, all state SHALL hold.
REQ-023 In EXEC with stall=0, the next edge SHALL load pc with next_pc, clear inst_valid and enter FETCH; minimum throughput is one instruction per 2 cycles.
REQ-024 next_pc SHALL be selected in this priority order:
- Jr: ReadData1.
- (Branch and Zero) or (nBranch and not Zero): AddrResult.
- Jmp or Jal: {pc_plus4[31:28], Instruction[25:0], 2'b00}.
- Otherwise: pc+4.
REQ-025 When more than one control input is asserted, the priority in REQ-024 SHALL resolve the conflict.
REQ-026 next_pc[1:0] SHALL be forced to 2'b00 before loading pc.
REQ-027 pc+4 SHALL be computed modulo 2^32: 32'hFFFFFFFC wraps to 32'h00000000.
REQ-028 branch_base_addr SHALL be combinational pc+4 at all times.
REQ-029 On an EXEC retire with Jal=1, link_addr SHALL load pc+4 at the same edge as pc.
REQ-030 link_addr SHALL hold its value otherwise.
REQ-031 Control inputs SHALL be ignored outside EXEC.
REQ-032 imem_rdata SHALL be ignored outside FETCH.

Reset
REQ-033 rst_n=0 SHALL immediately and asynchronously force:
- pc=RESET_PC, state=IDLE.
- Instruction=0, inst_valid=0, imem_req=0, link_addr=0.
REQ-034 Reset mid-fetch SHALL abort the outstanding request; a late imem_ready after reset release (while in IDLE) SHALL be ignored.
REQ-035 Reset release SHALL be sampled on clk; the first imem_req SHALL appear 1 cycle after release.

Verification
REQ-036 Sequential: memory always ready, no control inputs -> imem_addr sequence 0,4,8,C, each instruction valid for 1 cycle.
REQ-037 Branch: beq at pc=0x10, Zero=1, AddrResult=0x40 -> next imem_addr=0x40; same case with Zero=0 -> next imem_addr=0x14.
REQ-038 Jal: jal at pc=0x00400020, target field 0x0100000 -> pc=0x00400000 and link_addr=0x00400024; then jr with ReadData1=0x00400024 -> pc=0x00400024.
REQ-039 Handshake and stall: imem_ready held low 5 cycles -> imem_req high and imem_addr stable for all 5; stall=1 for 3 cycles in EXEC -> pc, Instruction and inst_valid=1 unchanged.
REQ-040 Reset and wrap: pc=0xFFFFFFFC, no control inputs -> next pc=0; rst_n pulsed low mid-FETCH -> outputs clear immediately, pc=RESET_PC, fetch restarts.
